// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_arb_pkg;

  localparam int XLEN = 32;
  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {GNT_NONE, GNT_PIPE, GNT_MC} wb_gnt_e;

endpackage

// File: rtl/wb_arb_if.sv
// Bus bundle between the WB stage / MC unit (master) and the write-port arbiter (slave).
interface wb_arb_if #(
  parameter int DEPTH = 4
);
  import wb_arb_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic            pipe_valid;
  logic [4:0]      pipe_reg;
  logic [XLEN-1:0] pipe_data;
  logic            pipe_stall;
  logic            mc_valid;
  logic            mc_ready;
  logic [4:0]      mc_reg;
  logic [XLEN-1:0] mc_data;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [CW-1:0]   q_count;

  modport master (
    output pipe_valid, pipe_reg, pipe_data, mc_valid, mc_reg, mc_data,
    input  pipe_stall, mc_ready, rf_we, rf_waddr, rf_wdata, q_count
  );

  modport slave (
    input  pipe_valid, pipe_reg, pipe_data, mc_valid, mc_reg, mc_data,
    output pipe_stall, mc_ready, rf_we, rf_waddr, rf_wdata, q_count
  );

endinterface

// File: rtl/wb_ret_fifo.sv
// Return queue for multi-cycle results; exposes per-entry rd/valid for the hazard compare.
module wb_ret_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  wb_req_t               push_req,
  input  logic                  pop,
  output wb_req_t               head,
  output logic [CW-1:0]         count,
  output logic [DEPTH-1:0]      entry_valid,
  output logic [DEPTH-1:0][4:0] entry_rd
);

  localparam int PW = $clog2(DEPTH);

  wb_req_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // NOTE: payload storage is deliberately not reset; entry_valid alone qualifies it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_req;
  end

  // Push and pop never target the same slot: that needs empty (no pop) or full (no push).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      if (push) begin
        wr_ptr              <= wr_ptr + PW'(1);
        entry_valid[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr              <= rd_ptr + PW'(1);
        entry_valid[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) entry_rd[i] = mem[i].rd;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: WB stage vs. queued MC returns, RAW-ordering stall.
// Optional starvation guard enabled by defining WB_ARB_STARVE_GUARD_EN.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 4
`ifdef WB_ARB_STARVE_GUARD_EN
  , parameter int STARVE_LIMIT = 8
`endif
) (
  input logic    clk,
  input logic    rst_n,
  wb_arb_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  wb_req_t               head;
  wb_req_t               sel_req;
  logic [CW-1:0]         count;
  logic [DEPTH-1:0]      entry_valid;
  logic [DEPTH-1:0][4:0] entry_rd;
  logic [DEPTH-1:0]      match;
  logic                  push;
  logic                  pop;
  logic                  q_nonempty;
  logic                  hazard;
  logic                  force_drain;
  wb_gnt_e               gnt;

  wb_ret_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_req    ('{rd: bus.mc_reg, data: bus.mc_data}),
    .pop         (pop),
    .head        (head),
    .count       (count),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  assign q_nonempty   = (count != '0);
  assign bus.mc_ready = (count < CW'(DEPTH));
  assign bus.q_count  = count;
  assign push         = bus.mc_valid & bus.mc_ready;

  // Only entries resident at cycle start are compared; this cycle's push is excluded.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++)
      match[i] = entry_valid[i] & (entry_rd[i] == bus.pipe_reg);
  end

  assign hazard = bus.pipe_valid & (bus.pipe_reg != REG_X0) & (|match);

`ifdef WB_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  // Counter never passes the limit: reaching it forces an MC grant, which clears it.
  assign force_drain = (starve_cnt == SW'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            starve_cnt <= '0;
    else if (gnt == GNT_MC || !q_nonempty) starve_cnt <= '0;
    else if (gnt == GNT_PIPE)              starve_cnt <= starve_cnt + SW'(1);
  end
`else
  assign force_drain = 1'b0;
`endif

  assign bus.pipe_stall = hazard | force_drain;

  always_comb begin
    gnt = GNT_NONE;
    if (force_drain && q_nonempty)             gnt = GNT_MC;
    else if (bus.pipe_valid && !bus.pipe_stall) gnt = GNT_PIPE;
    else if (q_nonempty)                       gnt = GNT_MC;
  end

  assign pop = (gnt == GNT_MC);

  always_comb begin
    sel_req = head;
    if (gnt == GNT_PIPE) sel_req = '{rd: bus.pipe_reg, data: bus.pipe_data};
  end

  // An x0 grant still updates address/data and consumes the request; only the enable drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
    end else begin
      bus.rf_we <= (gnt != GNT_NONE) && (sel_req.rd != REG_X0);
      if (gnt != GNT_NONE) begin
        bus.rf_waddr <= sel_req.rd;
        bus.rf_wdata <= sel_req.data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed + randomized bench for wb_port_arbiter against a queue-based reference model.
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_arb_if #(.DEPTH(DEPTH)) bus ();

  wb_port_arbiter #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  wb_req_t         mq[$];
  int              m_starve = 0;
  logic            m_we     = 1'b0;
  logic [4:0]      m_waddr  = '0;
  logic [XLEN-1:0] m_wdata  = '0;
  bit              m_stall  = 0;
  bit              m_ready  = 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pipe(input bit v, input logic [4:0] r, input logic [XLEN-1:0] d);
    bus.pipe_valid = v;
    bus.pipe_reg   = r;
    bus.pipe_data  = d;
  endtask

  task automatic set_mc(input bit v, input logic [4:0] r, input logic [XLEN-1:0] d);
    bus.mc_valid = v;
    bus.mc_reg   = r;
    bus.mc_data  = d;
  endtask

  function automatic bit guard_on();
`ifdef WB_ARB_STARVE_GUARD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic cycle();
    bit hz, fd, push;
    int g, sz;
    wb_req_t pin, min, h;
    #1;
    sz  = mq.size();
    pin = '{rd: bus.pipe_reg, data: bus.pipe_data};
    min = '{rd: bus.mc_reg, data: bus.mc_data};
    hz  = 0;
    if (bus.pipe_valid && bus.pipe_reg != REG_X0)
      foreach (mq[i]) if (mq[i].rd == bus.pipe_reg) hz = 1;
    fd      = guard_on() && (m_starve >= STARVE_LIMIT);
    m_stall = hz || fd;
    m_ready = (sz < DEPTH);
    check("pipe_stall", bus.pipe_stall, m_stall);
    check("mc_ready", bus.mc_ready, m_ready);
    if (fd && sz > 0)                    g = 2;
    else if (bus.pipe_valid && !m_stall) g = 1;
    else if (sz > 0)                     g = 2;
    else                                 g = 0;
    push = bus.mc_valid && m_ready;
    @(posedge clk);
    if (g == 1) begin
      m_we = (pin.rd != REG_X0); m_waddr = pin.rd; m_wdata = pin.data;
    end else if (g == 2) begin
      h = mq.pop_front();
      m_we = (h.rd != REG_X0); m_waddr = h.rd; m_wdata = h.data;
    end else begin
      m_we = 1'b0;
    end
    if (push) mq.push_back(min);
    if (g == 2 || sz == 0) m_starve = 0;
    else if (g == 1)       m_starve++;
    @(negedge clk);
    check("rf_we", bus.rf_we, m_we);
    check("rf_waddr", bus.rf_waddr, m_waddr);
    check("rf_wdata", bus.rf_wdata, m_wdata);
    check("q_count", bus.q_count, mq.size());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_q_count", bus.q_count, 0);
    check("rst_rf_we", bus.rf_we, 0);
    check("rst_rf_waddr", bus.rf_waddr, 0);
    check("rst_rf_wdata", bus.rf_wdata, 0);
    mq.delete();
    m_starve = 0; m_we = 0; m_waddr = '0; m_wdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int t_first, t_second, prev_q;
    bit hold_pipe, hold_mc;
    set_pipe(0, '0, '0);
    set_mc(0, '0, '0);
    do_reset();

    // 1: reset with three queued entries
    for (int i = 0; i < 3; i++) begin
      set_pipe(1, 5'(1 + i), 32'h100 + i);
      set_mc(1, 5'(10 + i), 32'hA0 + i);
      cycle();
    end
    set_pipe(0, '0, '0); set_mc(0, '0, '0);
    check("t1_prefill", bus.q_count, 3);
    do_reset();
    #1;
    check("t1_q_count", bus.q_count, 0);
    check("t1_rf_we", bus.rf_we, 0);
    check("t1_mc_ready", bus.mc_ready, 1);

    // 2: pipe-only write
    set_pipe(1, 5'd5, 32'h1234);
    cycle();
    set_pipe(0, '0, '0);
    check("t2_we", bus.rf_we, 1);
    check("t2_waddr", bus.rf_waddr, 5);
    check("t2_wdata", bus.rf_wdata, 32'h1234);

    // 3: MC return, two-cycle latency
    set_mc(1, 5'd7, 32'hBEEF);
    cycle();
    set_mc(0, '0, '0);
    check("t3_q1", bus.q_count, 1);
    check("t3_we_early", bus.rf_we, 0);
    cycle();
    check("t3_we", bus.rf_we, 1);
    check("t3_waddr", bus.rf_waddr, 7);
    check("t3_wdata", bus.rf_wdata, 32'hBEEF);
    check("t3_q0", bus.q_count, 0);

    // 4: RAW ordering against queued reg 9
    set_pipe(1, 5'd3, 32'h33);
    set_mc(1, 5'd9, 32'h99);
    cycle();
    set_mc(0, '0, '0);
    set_pipe(1, 5'd9, 32'h909);
    #1;
    check("t4_stall", bus.pipe_stall, 1);
    cycle();
    check("t4_mc_addr", bus.rf_waddr, 9);
    check("t4_mc_data", bus.rf_wdata, 32'h99);
    cycle();
    check("t4_pipe_data", bus.rf_wdata, 32'h909);
    set_pipe(0, '0, '0);

    // 5: fill, hold 5th return, pop+push keeps count
    set_pipe(1, 5'd2, 32'h22);
    for (int i = 0; i < 4; i++) begin
      set_mc(1, 5'(20 + i), 32'h200 + i);
      cycle();
    end
    set_mc(1, 5'd24, 32'h204);
    #1;
    check("t5_full", bus.q_count, 4);
    check("t5_not_ready", bus.mc_ready, 0);
    cycle();
    check("t5_held", bus.q_count, 4);
    set_pipe(0, '0, '0);
    cycle();
    check("t5_pop_only", bus.q_count, 3);
    cycle();
    check("t5_pop_push", bus.q_count, 3);
    set_mc(0, '0, '0);
    for (int i = 0; i < 3; i++) cycle();
    check("t5_last_addr", bus.rf_waddr, 24);

    // 6: x0 writes from pipe and MC
    set_pipe(1, REG_X0, 32'hDEAD);
    cycle();
    set_pipe(0, '0, '0);
    check("t6_pipe_x0", bus.rf_we, 0);
    set_mc(1, REG_X0, 32'h5);
    cycle();
    set_mc(0, '0, '0);
    cycle();
    check("t6_mc_x0", bus.rf_we, 0);
    check("t6_popped", bus.q_count, 0);

    // Starvation guard: pipe always busy, FIFO should still drain every 9 cycles
    if (guard_on()) begin
      set_pipe(1, 5'd1, 32'h11);
      for (int i = 0; i < 4; i++) begin
        set_mc(1, 5'(20 + i), 32'h300 + i);
        cycle();
      end
      set_mc(0, '0, '0);
      t_first = -1; t_second = -1;
      prev_q  = 4;
      for (int c = 0; c < 30; c++) begin
        cycle();
        if (int'(bus.q_count) < prev_q) begin
          if (t_first < 0) t_first = c;
          else if (t_second < 0) t_second = c;
        end
        prev_q = int'(bus.q_count);
      end
      check("starve_seen", (t_first >= 0 && t_second >= 0), 1);
      check("starve_period", t_second - t_first, STARVE_LIMIT + 1);
      set_pipe(0, '0, '0);
      while (mq.size() > 0) cycle();
    end

    // Randomized traffic honouring the hold protocol on both request sides
    for (int c = 0; c < 400; c++) begin
      hold_pipe = bus.pipe_valid && m_stall;
      hold_mc   = bus.mc_valid && !m_ready;
      if (!hold_pipe)
        set_pipe(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom);
      if (!hold_mc)
        set_mc(($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), $urandom);
      cycle();
    end
    set_pipe(0, '0, '0);
    set_mc(0, '0, '0);
    for (int c = 0; c < DEPTH + 2; c++) cycle();
    check("final_empty", bus.q_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
